// File: rtl/core_mem_arbiter_if.sv
// Core/memory bus bundle for core_mem_arbiter.
// The slave modport is the arbiter. The master modport is the environment,
// meaning the cores plus the memory model.
interface core_mem_arbiter_if #(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned WB_WIDTH = DATA_WIDTH / 8;

    // Core side, packed per channel
    logic [NUM_CORES-1:0]            core_req;
    logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata;
    logic [NUM_CORES*WB_WIDTH-1:0]   core_wb;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_rdata;
    logic [NUM_CORES-1:0]            core_stall;

    // Shared memory port
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [WB_WIDTH-1:0]   mem_wb;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output core_req, core_addr, core_wdata, core_wb, mem_rdata,
        input  core_rdata, core_stall, mem_en, mem_addr, mem_wdata, mem_wb
    );

    modport slave (
        input  core_req, core_addr, core_wdata, core_wb, mem_rdata,
        output core_rdata, core_stall, mem_en, mem_addr, mem_wdata, mem_wb
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// N-channel round-robin front-end that puts several cores onto one
// fixed-latency memory port. A write completes in its issue cycle. A read
// holds the bus until its data returns, and during that time the winning
// core is stalled. Read data is bypassed to the core in the completion
// cycle and held afterwards.
module core_mem_arbiter #(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input logic               clock_i,
    input logic               reset_i,
    core_mem_arbiter_if.slave bus
);
    localparam int unsigned WB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CORES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  grant_q, grant_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  win_next;
    logic [PTR_W-1:0]  sel_idx;
    logic              win_found;
    logic              issue;
    logic              issue_write;
    logic              done;
    int unsigned       cand;

    logic [ADDR_WIDTH-1:0] addr_ch  [NUM_CORES];
    logic [DATA_WIDTH-1:0] wdata_ch [NUM_CORES];
    logic [WB_WIDTH-1:0]   wb_ch    [NUM_CORES];
    logic [DATA_WIDTH-1:0] hold_q   [NUM_CORES];

    // Unpack the per-channel fields from the packed core buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            addr_ch[i]  = bus.core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_ch[i] = bus.core_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            wb_ch[i]    = bus.core_wb[i*WB_WIDTH +: WB_WIDTH];
        end
    end

    // Round-robin search: first requester at or above rr_ptr, wrapping at NUM_CORES
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            if (!win_found && bus.core_req[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
        win_next = (win_idx == LAST_CH) ? '0 : win_idx + PTR_W'(1);
    end

    // FSM next state: issue in IDLE, then count down the read latency in WAIT
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        lat_cnt_d   = lat_cnt_q;
        issue       = 1'b0;
        issue_write = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found && !reset_i) begin
                    issue    = 1'b1;
                    rr_ptr_d = win_next;
                    if (|wb_ch[win_idx]) begin
                        issue_write = 1'b1;
                    end else begin
                        grant_d   = win_idx;
                        lat_cnt_d = LAT_INIT;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port, per-core stall and read data bypass
    always_comb begin
        // When idle, the port still shows a real channel (rr_ptr) so that it never carries X
        sel_idx        = issue ? win_idx : rr_ptr_q;
        bus.mem_en     = issue;
        bus.mem_addr   = addr_ch[sel_idx];
        bus.mem_wdata  = wdata_ch[sel_idx];
        bus.mem_wb     = wb_ch[sel_idx];
        bus.core_stall = bus.core_req;
        bus.core_rdata = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (issue_write && win_idx == PTR_W'(i)) begin
                bus.core_stall[i] = 1'b0;
            end
            if (done && grant_q == PTR_W'(i)) begin
                bus.core_stall[i] = 1'b0;
                bus.core_rdata[i*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
            end else begin
                bus.core_rdata[i*DATA_WIDTH +: DATA_WIDTH] = hold_q[i];
            end
        end
    end

    // FSM, round-robin pointer, grant and latency registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Per-core read data hold, loaded in the completion cycle
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                hold_q[i] <= '0;
            end
        end else if (done) begin
            hold_q[grant_q] <= bus.mem_rdata;
        end
    end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- N-channel memory front-end for rv32e processor cores.
- Each core presents address, write data and per-byte write enables, and is held by its stall input until the access completes.
- The block round-robin arbitrates all cores onto one shared fixed-latency memory port, generates per-core stall, and returns read data per core.
- Successor to the single-core direct binding: parametrised core count, data width and memory latency, with arbitration and wait-state generation.

Parameters:
- NUM_CORES, 2, number of core channels (1..16).
- ADDR_WIDTH, 32, address bits per channel.
- DATA_WIDTH, 32, data bits per channel; multiple of 8.
- MEM_LATENCY, 2, cycles from read issue to valid mem_rdata; must be at least 1.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  NUM_CORES  per-core access request; held high until that core's stall is sampled low.
- core_addr  in  NUM_CORES*ADDR_WIDTH  packed per-core address; channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  in  NUM_CORES*DATA_WIDTH  packed per-core write data.
- core_wb  in  NUM_CORES*DATA_WIDTH/8  packed per-core byte write enables; all-zero means read.
- core_rdata  out  NUM_CORES*DATA_WIDTH  packed per-core read data, held until that core's next read completes.
- core_stall  out  NUM_CORES  per-core stall to the processor's stall input.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wb  out  DATA_WIDTH/8  memory byte write enables.
- mem_rdata  in  DATA_WIDTH  memory read data; valid exactly MEM_LATENCY cycles after a read issue.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high (reset).
- State: FSM {IDLE, WAIT}; rr_ptr (log2 NUM_CORES bits); grant index g; latency counter lat_cnt; per-core rdata hold registers.
- Reset values:
  - state=IDLE, rr_ptr=0, lat_cnt=0, all rdata holds=0.
  - While reset is high: mem_en=0 and core_stall=core_req.
- Arbitration in IDLE:
  - Winner w = first index with core_req set, searching upward from rr_ptr with wrap-around at NUM_CORES.
  - w is selected combinationally. In the same cycle: mem_en=1, and mem_addr/mem_wdata/mem_wb = channel w fields.
- Write (core_wb[w] nonzero):
  - Completes in the issue cycle: core_stall[w]=0 that cycle.
  - rr_ptr <= w+1 (mod NUM_CORES); state stays IDLE.
- Read (core_wb[w]==0):
  - core_stall[w]=1 in the issue cycle.
  - g<=w, lat_cnt<=MEM_LATENCY-1, state<=WAIT, rr_ptr<=w+1 (mod).
  - If MEM_LATENCY==1, WAIT is entered with lat_cnt=0.
- WAIT state:
  - mem_en=0; no new issue.
  - lat_cnt decrements each cycle.
  - Completion cycle is when lat_cnt==0 (cycle t+MEM_LATENCY for issue at t). In it: core_stall[g]=0, core_rdata[g]=mem_rdata (combinational bypass), hold[g]<=mem_rdata, state<=IDLE.
  - Next issue occurs no earlier than the cycle after completion.
- Stall rule, all states: core_stall[i]=core_req[i] unless core i completes this cycle. Non-requesting cores see stall=0.
- core_rdata[i] outside its completion cycle = hold[i].
- mem_addr, mem_wdata and mem_wb are don't-care when mem_en=0, but must not be X at the port; drive channel rr_ptr.
- No requests in IDLE: mem_en=0, rr_ptr unchanged.
- Requester drops core_req while stalled in WAIT: access still completes and hold is updated; the stall-low pulse is harmless.
- Reset mid-WAIT: abort immediately to IDLE; the late mem_rdata is ignored and holds are cleared.
- NUM_CORES==1: rr_ptr is constant 0; behaviour is otherwise identical.

Test Plan:
- Single read, NUM_CORES=2, MEM_LATENCY=2:
  - Stimulus: core0 reads 0x100 at cycle t; memory returns 0xDEADBEEF at t+2.
  - Required: mem_en=1 only at t; core_stall[0]=1 at t and t+1, 0 at t+2; core_rdata[0]=0xDEADBEEF from t+2 and held after.
- Single write:
  - Stimulus: core1 writes 0x55AA00FF with wb=0b0101 to 0x20.
  - Required: same-cycle mem_en=1, mem_wb=0b0101, mem_addr=0x20, core_stall[1]=0; next cycle mem_en=0.
- Simultaneous reads:
  - Stimulus: core0 and core1 both read from reset.
  - Required: core0 issues at t, completes at t+2. core1 stall is 1 through t+2, issues at t+3, completes at t+5. rr_ptr then=0.
- Fairness, NUM_CORES=4:
  - Stimulus: all four request writes continuously for 8 cycles.
  - Required: grant order is 0,1,2,3,0,1,2,3, with exactly one mem_en per cycle.
- Reset mid-WAIT:
  - Stimulus: assert reset one cycle after a core0 read issue; memory later returns 0x12345678.
  - Required: mem_en=0 during reset; core_rdata[0]=0; after release, a fresh core0 read issues normally.
- MEM_LATENCY=1:
  - Stimulus: core0 reads.
  - Required: stall=1 only in the issue cycle; data accepted at t+1; back-to-back reads issue every 2 cycles.
